bsg_comm_link_tx_sched: RTL and testbench

- Packet-aware round-robin scheduler that shares the fused core input of the comm link (core_valid_i / core_data_i / core_ready_o) among num_in_p on-chip requesters.
- Grants are held for a whole multi-word packet, so packets from different requesters never interleave on the link.
- Gated by the link's calibration-done status.
- Sits in the core clock domain between the requesters and the comm link core input.

---
 rtl/bsg_comm_link_tx_sched_if.sv | 27 ++
 rtl/bsg_comm_link_tx_sched.sv | 112 +++++++++++
 tb/tb_bsg_comm_link_tx_sched.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bsg_comm_link_tx_sched_if.sv
// Requester-side and link-side handshake bundle for the comm link TX scheduler.
// The slave modport is the scheduler's view; master is the view of whoever drives it.
interface bsg_comm_link_tx_sched_if #(
  parameter int unsigned num_in_p = 4,
  parameter int unsigned width_p  = 32
);
  localparam int unsigned src_w_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1;

  logic [num_in_p-1:0]         req_v_i;
  logic [num_in_p*width_p-1:0] req_data_i;
  logic [num_in_p-1:0]         req_yumi_o;
  logic                        link_v_o;
  logic [width_p-1:0]          link_data_o;
  logic                        link_ready_i;
  logic [src_w_lp-1:0]         link_src_o;
  logic                        busy_o;

  modport slave (
    input  req_v_i, req_data_i, link_ready_i,
    output req_yumi_o, link_v_o, link_data_o, link_src_o, busy_o
  );

  modport master (
    output req_v_i, req_data_i, link_ready_i,
    input  req_yumi_o, link_v_o, link_data_o, link_src_o, busy_o
  );
endinterface

// File: rtl/bsg_comm_link_tx_sched.sv
// Packet-aware round-robin scheduler feeding the comm link core input.
// The grant is held from a header word until its length field of body words has been sent.
module bsg_comm_link_tx_sched #(
  parameter int unsigned num_in_p    = 4,
  parameter int unsigned width_p     = 32,
  parameter int unsigned len_width_p = 4
) (
  input  logic clk_i,
  input  logic async_reset_i,
  input  logic calib_done_i,
  bsg_comm_link_tx_sched_if.slave io
);
  localparam int unsigned src_w_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1;

  typedef enum logic {e_idle, e_locked} state_e;

  state_e                 state_q, state_d;
  logic [src_w_lp-1:0]    last_q, last_d;
  logic [src_w_lp-1:0]    owner_q, owner_d;
  logic [len_width_p-1:0] cnt_q, cnt_d;

  logic [src_w_lp-1:0]    sel_c;
  logic                   found_c;
  logic [src_w_lp-1:0]    src_c;
  logic [width_p-1:0]     data_c;
  logic [len_width_p-1:0] len_c;
  logic                   v_c;
  logic                   xfer_c;

  // Round-robin scan starting just after the last granted requester.
  always_comb begin
    int unsigned idx;
    sel_c   = last_q;
    found_c = 1'b0;
    for (int unsigned k = 1; k <= num_in_p; k++) begin
      idx = (32'(last_q) + k) % num_in_p;
      if (!found_c && io.req_v_i[idx]) begin
        sel_c   = src_w_lp'(idx);
        found_c = 1'b1;
      end
    end
  end

  assign src_c  = (state_q == e_locked) ? owner_q : sel_c;
  assign data_c = io.req_data_i[32'(src_c)*width_p +: width_p];
  assign len_c  = data_c[len_width_p-1:0];

  // link_v_o never looks at link_ready_i; reset forces it low immediately.
  always_comb begin
    v_c = 1'b0;
    if (!async_reset_i && calib_done_i) begin
      v_c = (state_q == e_locked) ? io.req_v_i[owner_q] : (|io.req_v_i);
    end
  end

  assign xfer_c = v_c & io.link_ready_i;

  always_comb begin
    io.req_yumi_o = '0;
    for (int unsigned i = 0; i < num_in_p; i++) begin
      io.req_yumi_o[i] = xfer_c && (src_c == src_w_lp'(i));
    end
  end

  assign io.link_v_o    = v_c;
  assign io.link_data_o = data_c;
  assign io.link_src_o  = src_c;
  assign io.busy_o      = (state_q == e_locked) && !async_reset_i;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (state_q == e_idle) begin
      if (xfer_c) begin
        last_d = sel_c;
        if (len_c != '0) begin
          owner_d = sel_c;
          cnt_d   = len_c;
          state_d = e_locked;
        end
      end
    end else begin
      if (xfer_c) begin
        cnt_d = cnt_q - len_width_p'(1);
        if (cnt_q == len_width_p'(1)) state_d = e_idle;
      end
    end
  end

  always_ff @(posedge clk_i or posedge async_reset_i) begin
    if (async_reset_i) begin
      state_q <= e_idle;
      last_q  <= src_w_lp'(num_in_p - 1);
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  a_src_stable: assert property (@(posedge clk_i) disable iff (async_reset_i)
    (state_q == e_locked && $past(state_q) == e_locked) |-> $stable(io.link_src_o));
  a_yumi_onehot: assert property (@(posedge clk_i) disable iff (async_reset_i)
    $onehot0(io.req_yumi_o));
  a_no_xfer_uncal: assert property (@(posedge clk_i) disable iff (async_reset_i)
    !calib_done_i |-> !xfer_c);
endmodule

// File: tb/tb_bsg_comm_link_tx_sched.sv
// Directed vector bench for bsg_comm_link_tx_sched (num_in_p=4, width_p=32, len_width_p=4).
module tb_bsg_comm_link_tx_sched;
  logic clk_i;
  logic async_reset_i;
  logic calib_done_i;

  bsg_comm_link_tx_sched_if #(.num_in_p(4), .width_p(32)) bus ();

  bsg_comm_link_tx_sched #(.num_in_p(4), .width_p(32), .len_width_p(4)) dut (
    .clk_i        (clk_i),
    .async_reset_i(async_reset_i),
    .calib_done_i (calib_done_i),
    .io           (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         rst;
    logic         calib;
    logic         ready;
    logic [3:0]   req_v;
    logic [127:0] data;
    logic         exp_v;
    logic [1:0]   exp_src;
    logic [3:0]   exp_yumi;
    logic         exp_busy;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [31:0] mk(input int r, input int len);
    return {24'hC0DE00, 4'(r), 4'(len)};
  endfunction

  task automatic add(input logic rst, input logic calib, input logic ready, input logic [3:0] rv,
                     input int l0, input int l1, input int l2, input int l3,
                     input logic ev, input int es, input logic [3:0] ey, input logic eb);
    vec_t v;
    v.rst      = rst;
    v.calib    = calib;
    v.ready    = ready;
    v.req_v    = rv;
    v.data     = {mk(3, l3), mk(2, l2), mk(1, l1), mk(0, l0)};
    v.exp_v    = ev;
    v.exp_src  = 2'(es);
    v.exp_yumi = ey;
    v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  initial begin
    logic [31:0] ed;
    int          n3;
    int          other;
    logic        seen0;

    async_reset_i    = 1'b1;
    calib_done_i     = 1'b1;
    bus.req_v_i      = '0;
    bus.req_data_i   = '0;
    bus.link_ready_i = 1'b0;

    // Reset state
    add(1, 1, 1, 4'hF, 0, 0, 0, 0,  0, 0, 4'h0, 0);
    // All valid, single-word packets: rotation 0,1,2,3,0,1
    add(0, 1, 1, 4'hF, 0, 0, 0, 0,  1, 0, 4'h1, 0);
    add(0, 1, 1, 4'hF, 0, 0, 0, 0,  1, 1, 4'h2, 0);
    add(0, 1, 1, 4'hF, 0, 0, 0, 0,  1, 2, 4'h4, 0);
    add(0, 1, 1, 4'hF, 0, 0, 0, 0,  1, 3, 4'h8, 0);
    add(0, 1, 1, 4'hF, 0, 0, 0, 0,  1, 0, 4'h1, 0);
    add(0, 1, 1, 4'hF, 0, 0, 0, 0,  1, 1, 4'h2, 0);
    // Req 2 len=3 packet while req 0 waits; body length fields are not decoded
    add(0, 1, 1, 4'h5, 0, 0, 3, 0,  1, 2, 4'h4, 0);
    add(0, 1, 1, 4'h5, 0, 0, 15, 0, 1, 2, 4'h4, 1);
    add(0, 1, 1, 4'h5, 0, 0, 15, 0, 1, 2, 4'h4, 1);
    add(0, 1, 1, 4'h5, 0, 0, 15, 0, 1, 2, 4'h4, 1);
    add(0, 1, 1, 4'h5, 0, 0, 0, 0,  1, 0, 4'h1, 0);
    // Owner bubble at cnt=2: five cycles idle, others ignored
    add(0, 1, 1, 4'h2, 0, 3, 0, 0,  1, 1, 4'h2, 0);
    add(0, 1, 1, 4'h2, 0, 0, 0, 0,  1, 1, 4'h2, 1);
    for (int k = 0; k < 5; k++) add(0, 1, 1, 4'hD, 0, 0, 0, 0, 0, 1, 4'h0, 1);
    add(0, 1, 1, 4'hF, 0, 0, 0, 0,  1, 1, 4'h2, 1);
    add(0, 1, 1, 4'hF, 0, 0, 0, 0,  1, 1, 4'h2, 1);
    add(0, 1, 1, 4'hF, 0, 0, 0, 0,  1, 2, 4'h4, 0);
    // link_v_o asserted regardless of link_ready_i
    add(0, 1, 0, 4'hF, 0, 0, 0, 0,  1, 3, 4'h0, 0);
    add(0, 1, 1, 4'hF, 0, 0, 0, 0,  1, 3, 4'h8, 0);
    // Calibration gating from reset, then mid-packet freeze and resume
    add(1, 0, 1, 4'h5, 2, 0, 0, 0,  0, 0, 4'h0, 0);
    add(0, 0, 1, 4'h5, 2, 0, 0, 0,  0, 0, 4'h0, 0);
    add(0, 0, 1, 4'h5, 2, 0, 0, 0,  0, 0, 4'h0, 0);
    add(0, 1, 1, 4'h5, 2, 0, 0, 0,  1, 0, 4'h1, 0);
    add(0, 1, 1, 4'h5, 9, 0, 0, 0,  1, 0, 4'h1, 1);
    for (int k = 0; k < 3; k++) add(0, 0, 1, 4'h5, 9, 0, 0, 0, 0, 0, 4'h0, 1);
    add(0, 1, 1, 4'h5, 9, 0, 0, 0,  1, 0, 4'h1, 1);
    add(0, 1, 1, 4'h5, 0, 0, 0, 0,  1, 2, 4'h4, 0);
    // Wrap 3->0, then reset at cnt=2 and priority back to req 0
    add(0, 1, 1, 4'h1, 3, 0, 0, 0,  1, 0, 4'h1, 0);
    add(0, 1, 1, 4'h1, 0, 0, 0, 0,  1, 0, 4'h1, 1);
    add(1, 1, 1, 4'h1, 0, 0, 0, 0,  0, 0, 4'h0, 0);
    add(0, 1, 1, 4'hF, 0, 0, 0, 0,  1, 0, 4'h1, 0);
    add(0, 1, 1, 4'hF, 0, 0, 0, 0,  1, 1, 4'h2, 0);

    foreach (vecs[i]) begin
      @(negedge clk_i);
      async_reset_i    = vecs[i].rst;
      calib_done_i     = vecs[i].calib;
      bus.link_ready_i = vecs[i].ready;
      bus.req_v_i      = vecs[i].req_v;
      bus.req_data_i   = vecs[i].data;
      #1;
      chk($sformatf("v%0d link_v", i), 32'(bus.link_v_o), 32'(vecs[i].exp_v));
      chk($sformatf("v%0d yumi", i), 32'(bus.req_yumi_o), 32'(vecs[i].exp_yumi));
      chk($sformatf("v%0d busy", i), 32'(bus.busy_o), 32'(vecs[i].exp_busy));
      if (!vecs[i].rst) chk($sformatf("v%0d src", i), 32'(bus.link_src_o), 32'(vecs[i].exp_src));
      if (vecs[i].exp_v) begin
        ed = vecs[i].data[32*int'(vecs[i].exp_src) +: 32];
        chk($sformatf("v%0d data", i), bus.link_data_o, ed);
      end
    end

    // Max-length packet from req 3 with link_ready_i toggling
    @(negedge clk_i);
    async_reset_i = 1'b1;
    @(negedge clk_i);
    async_reset_i    = 1'b0;
    calib_done_i     = 1'b1;
    bus.link_ready_i = 1'b1;
    bus.req_v_i      = 4'h8;
    bus.req_data_i   = {mk(3, 15), mk(2, 0), mk(1, 0), mk(0, 0)};
    #1;
    chk("len15 header yumi", 32'(bus.req_yumi_o), 32'h8);
    n3    = (bus.req_yumi_o == 4'h8) ? 1 : 0;
    other = 0;
    seen0 = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk_i);
      bus.req_v_i      = 4'h9;
      bus.req_data_i   = {mk(3, 5), mk(2, 0), mk(1, 0), mk(0, 0)};
      bus.link_ready_i = (k % 2 == 1);
      #1;
      if (bus.req_yumi_o[3]) n3++;
      if (bus.req_yumi_o[1] || bus.req_yumi_o[2]) other++;
      if (bus.req_yumi_o[0]) begin
        seen0 = 1'b1;
        chk("len15 busy after", 32'(bus.busy_o), 32'h0);
        break;
      end
    end
    chk("len15 owner transfers", 32'(n3), 32'd16);
    chk("len15 next grant req0", 32'(seen0), 32'h1);
    chk("len15 stray grants", 32'(other), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
